// File: rtl/axis_acc_serializer_pkg.sv
// Shared parameters and types for the accumulator-tile serializer.
// Width macros default here; ACC_SERIALIZER_SAT_EN enables output saturation.
`ifndef COLS
`define COLS 4
`endif
`ifndef ROWS
`define ROWS 2
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef TUSER_WIDTH
`define TUSER_WIDTH 8
`endif

package axis_acc_serializer_pkg;
  typedef logic [`TUSER_WIDTH-1:0] tuser_st;
  typedef enum logic {EMPTY = 1'b0, SHIFT = 1'b1} ser_state_e;
endpackage

// File: rtl/axis_acc_serializer_sat.sv
// acc_sat: ROWS parallel signed clamps to a W-bit range, sign-extended back to WACC.
module acc_sat #(
  parameter int ROWS = 2,
  parameter int WACC = 32,
  parameter int W    = 8
) (
  input  logic [ROWS-1:0][WACC-1:0] din_i,
  output logic [ROWS-1:0][WACC-1:0] dout_o
);
  localparam logic signed [WACC-1:0] MAXV = {{(WACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WACC-1:0] MINV = {{(WACC-W+1){1'b1}}, {(W-1){1'b0}}};

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [WACC-1:0] w;
    assign w         = din_i[r];
    assign dout_o[r] = (w > MAXV) ? MAXV : (w < MINV) ? MINV : w;
  end
endmodule

// File: rtl/axis_acc_serializer.sv
// Serializes one COLSxROWS accumulator tile into COLS column beats, 1 beat/cycle sustained.
// Define ACC_SERIALIZER_SAT_EN to clamp output words to `WORD_WIDTH signed.
module axis_acc_serializer
  import axis_acc_serializer_pkg::*;
(
  input  logic                                               aclk,
  input  logic                                               aresetn,
  input  logic                                               s_axis_tvalid,
  output logic                                               s_axis_tready,
  input  logic [`COLS-1:0][`ROWS-1:0][`WORD_WIDTH_ACC-1:0]   s_axis_tdata,
  input  tuser_st                                            s_axis_tuser,
  input  logic                                               s_axis_tlast,
  output logic                                               m_axis_tvalid,
  input  logic                                               m_axis_tready,
  output logic [`ROWS-1:0][`WORD_WIDTH_ACC-1:0]              m_axis_tdata,
  output tuser_st                                            m_axis_tuser,
  output logic                                               m_axis_tlast
);
  localparam int COLS           = `COLS;
  localparam int ROWS           = `ROWS;
  localparam int WORD_WIDTH_ACC = `WORD_WIDTH_ACC;
  localparam int TUSER_WIDTH    = `TUSER_WIDTH;
  localparam int COL_W          = (COLS > 1) ? $clog2(COLS) : 1;

  ser_state_e                                    state_q;
  logic [COL_W-1:0]                              col_q;
  logic [COLS-1:0][ROWS-1:0][WORD_WIDTH_ACC-1:0] tile_q;
  logic [TUSER_WIDTH-1:0]                        user_q;
  logic                                          last_q;

  logic                           last_col, s_hs, m_hs;
  logic [ROWS-1:0][WORD_WIDTH_ACC-1:0] col_data;

  assign last_col      = (col_q == COL_W'(COLS-1));
  assign s_axis_tready = (state_q == EMPTY) | (m_axis_tready & last_col);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  // A new tile may land in the same cycle the last column leaves: no bubble.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      col_q   <= '0;
      tile_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_hs) begin
      state_q <= SHIFT;
      col_q   <= '0;
      tile_q  <= s_axis_tdata;
      user_q  <= s_axis_tuser;
      last_q  <= s_axis_tlast;
    end else if (m_hs) begin
      if (last_col) state_q <= EMPTY;
      else          col_q   <= col_q + COL_W'(1);
    end
  end

  assign col_data      = tile_q[col_q];
  assign m_axis_tvalid = (state_q == SHIFT);
  assign m_axis_tuser  = tuser_st'(user_q);
  // Gated by state so tlast never lingers high on an idle bus.
  assign m_axis_tlast  = (state_q == SHIFT) & last_q & last_col;

`ifdef ACC_SERIALIZER_SAT_EN
  acc_sat #(
    .ROWS (ROWS),
    .WACC (WORD_WIDTH_ACC),
    .W    (`WORD_WIDTH)
  ) u_sat (
    .din_i  (col_data),
    .dout_o (m_axis_tdata)
  );
`else
  assign m_axis_tdata = col_data;
`endif
endmodule

// File: doc/axis_acc_serializer.md
AXIS_ACC_SERIALIZER -- requirements
Module: axis_acc_serializer

Interface
REQ-001 SHALL have localparam COLS, default `COLS: columns per input beat, which is also output beats per input beat.
REQ-002 SHALL have localparam ROWS, default `ROWS: accumulator words per output beat.
REQ-003 SHALL have localparam WORD_WIDTH_ACC, default `WORD_WIDTH_ACC: accumulator word width.
REQ-004 SHALL have localparam TUSER_WIDTH, default `TUSER_WIDTH: width of tuser_st.
REQ-005 SHALL have port aclk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port s_axis_tvalid, input, 1: input beat valid.
REQ-008 SHALL have port s_axis_tready, output, 1: input beat accepted when high with tvalid.
REQ-009 SHALL have port s_axis_tdata, input, COLS x ROWS x WORD_WIDTH_ACC: full accumulator tile.
REQ-010 SHALL have port s_axis_tuser, input, tuser_st: tile sideband.
REQ-011 SHALL have port s_axis_tlast, input, 1: last tile of packet.
REQ-012 SHALL have port m_axis_tvalid, output, 1: output beat valid.
REQ-013 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-014 SHALL have port m_axis_tdata, output, ROWS x WORD_WIDTH_ACC: one column of the tile.
REQ-015 SHALL have port m_axis_tuser, output, tuser_st: sideband of the tile being emitted.
REQ-016 SHALL have port m_axis_tlast, output, 1: last beat of packet.

Function
REQ-017 SHALL implement a two-state FSM: EMPTY (no tile held) and SHIFT (tile held, emitting columns).
REQ-018 SHALL capture s_axis_tdata, tuser and tlast into a holding register on each s handshake, and set col to 0.
REQ-019 SHALL drive s_axis_tready = (state==EMPTY) | (m_axis_tready & col==COLS-1); the output is combinational from registered state and m_axis_tready only, never from s_axis_tvalid.
REQ-020 SHALL have a latency of exactly 1 cycle: m_axis_tvalid rises on the clock edge after the s handshake.
REQ-021 SHALL drive m_axis_tdata from column col of the held tile (column 0 first, ascending order), m_axis_tvalid = (state==SHIFT), and hold all m outputs stable while tvalid & ~tready.
REQ-022 SHALL increment col on each m handshake with col<COLS-1.
REQ-023 SHALL, on an m handshake at col==COLS-1 with s_axis_tvalid high, load the new tile, set col to 0 and stay in SHIFT, giving a sustained throughput of 1 beat per cycle with no bubble.
REQ-024 SHALL, on an m handshake at col==COLS-1 with s_axis_tvalid low, go to EMPTY.
REQ-025 SHALL drive m_axis_tuser with the held tile's tuser on every beat of that tile.
REQ-026 SHALL drive m_axis_tlast = held_tlast & (col==COLS-1).
REQ-027 SHALL handle COLS==1 correctly: every beat is last-column, and the throughput rule of REQ-023 still applies.

Reset
REQ-028 SHALL, while aresetn is low at a clock edge, set state to EMPTY, col to 0, m_axis_tvalid to 0, m_axis_tlast to 0 and s_axis_tready to 1 after the edge; held data resets to 0.
REQ-029 SHALL discard a partially emitted tile on reset mid-operation, with no further beats of it emitted.

Configuration
REQ-030 SHALL, with ACC_SERIALIZER_SAT_EN defined, saturate each output word signed to the range [-2^(`WORD_WIDTH-1), 2^(`WORD_WIDTH-1)-1] and sign-extend it to WORD_WIDTH_ACC, combinationally on the output path with no added latency.
REQ-031 SHALL, with ACC_SERIALIZER_SAT_EN undefined, pass words unmodified and instantiate no saturation logic.

Structure
REQ-032 SHALL use tuser_st and the width macros from the shared params package; no new typedefs are local to the module.
REQ-033 SHALL place saturation in one sub-module, acc_sat (ROWS parallel clamps), instantiated only under ACC_SERIALIZER_SAT_EN.

Verification
REQ-034 SHALL cover single tile: COLS=4, ROWS=2, tile words = col*16+row, tlast=1, m_tready=1 -> 4 beats on cycles 1..4 with data {0,1},{16,17},{32,33},{48,49}, tlast only on beat 4, s_tready low on cycles 1..3.
REQ-035 SHALL cover back-to-back: 3 tiles with s_tvalid held high and m_tready=1 -> 12 consecutive beats with no gap, and s_tready high only at col==3.
REQ-036 SHALL cover backpressure: m_tready toggled 1,0,0,1,... -> m_tdata, m_tuser and m_tlast stable during stalls, columns in order, none dropped or duplicated.
REQ-037 SHALL cover reset mid-tile: aresetn low for one cycle after beat 2 -> m_tvalid=0 next cycle, and the next accepted tile starts at column 0.
REQ-038 SHALL cover saturation with the macro defined and `WORD_WIDTH=8: inputs 300, -300, 5 -> outputs 127, -128, 5; with the macro undefined -> outputs 300, -300, 5.
REQ-039 SHALL cover tuser: per-tile distinct tuser values -> each value appears on all COLS beats of its tile only.
